mem_arb_ctrl: RTL

Two-port arbiter and sequencer in front of `mem_sys`, the 4-bank x (1024×1) / 4-bank w (1M×1) bit memory system. It shares the memory between a loader requester (L) and a compute-engine requester (E), issuing at most one command per side (x, w) per cycle. It also serialises the single shared `write_data` line and returns read bits with a fixed latency. All `mem_sys` control inputs are driven from registers.

---
 rtl/mem_arb_ctrl_if.sv | 63 ++++++
 rtl/mem_arb_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_arb_ctrl_if.sv
// Request/response and mem_sys command bundle for mem_arb_ctrl.
// slave = arbiter side, master = requesters plus memory system.
interface mem_arb_ctrl_if #(
  parameter int XA_W = 10,
  parameter int WA_W = 20
);
  logic            l_valid;
  logic            l_ready;
  logic            l_side;
  logic [1:0]      l_bank;
  logic [WA_W-1:0] l_addr;
  logic            l_we;
  logic            l_wdata;
  logic            l_rsp_valid;
  logic            l_rsp_side;
  logic            l_rsp_data;

  logic            e_valid;
  logic            e_ready;
  logic            e_side;
  logic [1:0]      e_bank;
  logic [WA_W-1:0] e_addr;
  logic            e_we;
  logic            e_wdata;
  logic            e_rsp_valid;
  logic            e_rsp_side;
  logic            e_rsp_data;

  logic            read_rq_x;
  logic            write_rq_x;
  logic [1:0]      sel_x;
  logic [XA_W-1:0] rw_address_x;
  logic            read_rq_w;
  logic            write_rq_w;
  logic [1:0]      sel_w;
  logic [WA_W-1:0] rw_address;
  logic            write_data;
  logic            vdd;
  logic            read_data_x;
  logic            read_data_w;

  modport slave (
    input  l_valid, l_side, l_bank, l_addr, l_we, l_wdata,
    output l_ready, l_rsp_valid, l_rsp_side, l_rsp_data,
    input  e_valid, e_side, e_bank, e_addr, e_we, e_wdata,
    output e_ready, e_rsp_valid, e_rsp_side, e_rsp_data,
    output read_rq_x, write_rq_x, sel_x, rw_address_x,
    output read_rq_w, write_rq_w, sel_w, rw_address,
    output write_data, vdd,
    input  read_data_x, read_data_w
  );

  modport master (
    output l_valid, l_side, l_bank, l_addr, l_we, l_wdata,
    input  l_ready, l_rsp_valid, l_rsp_side, l_rsp_data,
    output e_valid, e_side, e_bank, e_addr, e_we, e_wdata,
    input  e_ready, e_rsp_valid, e_rsp_side, e_rsp_data,
    input  read_rq_x, write_rq_x, sel_x, rw_address_x,
    input  read_rq_w, write_rq_w, sel_w, rw_address,
    input  write_data, vdd,
    output read_data_x, read_data_w
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Two-requester (L/E) round-robin arbiter and sequencer for mem_sys.
// Optional MEM_ARB_XADDR_CHECK_EN: reject out-of-range x addresses via x_addr_err.
module mem_arb_ctrl #(
  parameter int XA_W = 10,
  parameter int WA_W = 20
) (
  input  logic           clk,
  input  logic           rst,
  mem_arb_ctrl_if.slave  bus
`ifdef MEM_ARB_XADDR_CHECK_EN
  ,
  output logic           x_addr_err
`endif
);

  logic            rr_x, rr_w, wr_turn;
  logic            x_who, w_who;

  logic            l_x, l_w, e_x, e_w;
  logic            x_has, w_has;
  logic            x_pick_e, w_pick_e;
  logic            x_we, w_we;
  logic            x_wdata, w_wdata;
  logic [1:0]      x_bank, w_bank;
  logic [XA_W-1:0] x_addr;
  logic [WA_W-1:0] w_addr;
  logic            x_bad;
  logic            x_is_wr, w_is_wr, both_wr;
  logic            grant_x, grant_w;
  logic            issue_x, issue_w;
  logic            l_hit_x, l_hit_w, e_hit_x, e_hit_w;

  always_comb begin
    l_x = bus.l_valid & ~bus.l_side;
    l_w = bus.l_valid &  bus.l_side;
    e_x = bus.e_valid & ~bus.e_side;
    e_w = bus.e_valid &  bus.e_side;

    x_has    = l_x | e_x;
    w_has    = l_w | e_w;
    x_pick_e = e_x & (~l_x | rr_x);
    w_pick_e = e_w & (~l_w | rr_w);

    x_we    = x_pick_e ? bus.e_we    : bus.l_we;
    x_wdata = x_pick_e ? bus.e_wdata : bus.l_wdata;
    x_bank  = x_pick_e ? bus.e_bank  : bus.l_bank;
    x_addr  = x_pick_e ? bus.e_addr[XA_W-1:0] : bus.l_addr[XA_W-1:0];

    w_we    = w_pick_e ? bus.e_we    : bus.l_we;
    w_wdata = w_pick_e ? bus.e_wdata : bus.l_wdata;
    w_bank  = w_pick_e ? bus.e_bank  : bus.l_bank;
    w_addr  = w_pick_e ? bus.e_addr  : bus.l_addr;
  end

`ifdef MEM_ARB_XADDR_CHECK_EN
  logic [WA_W-1:0] x_addr_full;
  always_comb begin
    x_addr_full = x_pick_e ? bus.e_addr : bus.l_addr;
    x_bad       = x_has & (|x_addr_full[WA_W-1:XA_W]);
  end
`else
  always_comb x_bad = 1'b0;
`endif

  // A rejected x request issues nothing, so it never competes for write_data.
  always_comb begin
    x_is_wr = x_has & x_we & ~x_bad;
    w_is_wr = w_has & w_we;
    both_wr = x_is_wr & w_is_wr;
    grant_x = x_has & ~(both_wr &  wr_turn);
    grant_w = w_has & ~(both_wr & ~wr_turn);
    issue_x = grant_x & ~x_bad;
    issue_w = grant_w;
  end

  always_comb begin
    bus.l_ready = (l_x & ~x_pick_e & grant_x) | (l_w & ~w_pick_e & grant_w);
    bus.e_ready = (e_x &  x_pick_e & grant_x) | (e_w &  w_pick_e & grant_w);
    bus.vdd     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_x    <= 1'b0;
      rr_w    <= 1'b0;
      wr_turn <= 1'b0;
    end else begin
      if (l_x & e_x & grant_x) rr_x <= ~rr_x;
      if (l_w & e_w & grant_w) rr_w <= ~rr_w;
      if (both_wr) wr_turn <= ~wr_turn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.read_rq_x    <= 1'b0;
      bus.write_rq_x   <= 1'b0;
      bus.sel_x        <= '0;
      bus.rw_address_x <= '0;
      x_who            <= 1'b0;
      bus.read_rq_w    <= 1'b0;
      bus.write_rq_w   <= 1'b0;
      bus.sel_w        <= '0;
      bus.rw_address   <= '0;
      w_who            <= 1'b0;
      bus.write_data   <= 1'b0;
    end else begin
      bus.read_rq_x  <= issue_x & ~x_we;
      bus.write_rq_x <= issue_x &  x_we;
      if (issue_x) begin
        bus.sel_x        <= x_bank;
        bus.rw_address_x <= x_addr;
        x_who            <= x_pick_e;
      end
      bus.read_rq_w  <= issue_w & ~w_we;
      bus.write_rq_w <= issue_w &  w_we;
      if (issue_w) begin
        bus.sel_w      <= w_bank;
        bus.rw_address <= w_addr;
        w_who          <= w_pick_e;
      end
      if (issue_x & x_we)      bus.write_data <= x_wdata;
      else if (issue_w & w_we) bus.write_data <= w_wdata;
    end
  end

`ifdef MEM_ARB_XADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) x_addr_err <= 1'b0;
    else      x_addr_err <= grant_x & x_bad;
  end
`endif

  always_comb begin
    l_hit_x = bus.read_rq_x & ~x_who;
    l_hit_w = bus.read_rq_w & ~w_who;
    e_hit_x = bus.read_rq_x &  x_who;
    e_hit_w = bus.read_rq_w &  w_who;
  end

  // Each requester has at most one read in flight per cycle, so one hit per side.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.l_rsp_valid <= 1'b0;
      bus.l_rsp_side  <= 1'b0;
      bus.l_rsp_data  <= 1'b0;
      bus.e_rsp_valid <= 1'b0;
      bus.e_rsp_side  <= 1'b0;
      bus.e_rsp_data  <= 1'b0;
    end else begin
      bus.l_rsp_valid <= l_hit_x | l_hit_w;
      if (l_hit_x) begin
        bus.l_rsp_side <= 1'b0;
        bus.l_rsp_data <= bus.read_data_x;
      end else if (l_hit_w) begin
        bus.l_rsp_side <= 1'b1;
        bus.l_rsp_data <= bus.read_data_w;
      end
      bus.e_rsp_valid <= e_hit_x | e_hit_w;
      if (e_hit_x) begin
        bus.e_rsp_side <= 1'b0;
        bus.e_rsp_data <= bus.read_data_x;
      end else if (e_hit_w) begin
        bus.e_rsp_side <= 1'b1;
        bus.e_rsp_data <= bus.read_data_w;
      end
    end
  end

endmodule
